// File: rtl/mastermind_pkg.sv
// Shared types and helpers for the Mastermind codebreaker.
package mastermind_pkg;

  localparam int COLOR_W    = 3;
  localparam int NUM_POS    = 4;
  localparam int NUM_COLORS = 8;
  localparam int GUESS_W    = COLOR_W * NUM_POS;

  typedef enum logic [3:0] {
    IDLE,
    SWEEP_ISSUE,
    SWEEP_WAIT,
    PLACE_SEL,
    PLACE_ISSUE,
    PLACE_WAIT,
    FINAL_ISSUE,
    FINAL_WAIT,
    DONE,
    FAIL
  } solver_state_t;

  // Position 0 lands in the least significant colour field.
  function automatic logic [GUESS_W-1:0] pack_guess(input logic [COLOR_W-1:0] c0,
                                                    input logic [COLOR_W-1:0] c1,
                                                    input logic [COLOR_W-1:0] c2,
                                                    input logic [COLOR_W-1:0] c3);
    return {c3, c2, c1, c0};
  endfunction

endpackage

// File: rtl/mastermind_color_table.sv
// Per-colour occurrence counts learned during the sweep, the filler colour
// (first colour known to be absent) and the running totals used by placement.
module mastermind_color_table
  import mastermind_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [COLOR_W-1:0] wr_idx,
  input  logic [2:0]         wr_val,
  input  logic               dec_en,
  input  logic [COLOR_W-1:0] dec_idx,
  input  logic [COLOR_W-1:0] rd_idx,
  output logic [2:0]         rd_count,
  output logic [3:0]         sum,
  output logic [3:0]         remaining,
  output logic [COLOR_W-1:0] filler,
  output logic               filler_known
);

  logic [2:0] count_q [NUM_COLORS];

  assign rd_count = count_q[rd_idx];

  // Count table: cleared on start, written by sweep feedback, decremented as positions are assigned.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_COLORS; i++) count_q[i] <= '0;
      sum          <= '0;
      remaining    <= '0;
      filler       <= '0;
      filler_known <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < NUM_COLORS; i++) count_q[i] <= '0;
      sum          <= '0;
      remaining    <= '0;
      filler       <= '0;
      filler_known <= 1'b0;
    end else if (wr_en) begin
      count_q[wr_idx] <= wr_val;
      sum             <= sum + {1'b0, wr_val};
      remaining       <= remaining + {1'b0, wr_val};
      if (wr_val == 3'd0 && !filler_known) begin
        filler       <= wr_idx;
        filler_known <= 1'b1;
      end
    end else if (dec_en) begin
      count_q[dec_idx] <= count_q[dec_idx] - 3'd1;
      remaining        <= remaining - 4'd1;
    end
  end

endmodule

// File: rtl/mastermind_solver.sv
// Mastermind codebreaker: sweeps single-colour guesses to learn colour counts,
// then places colours one position at a time against a known-absent filler,
// and finally confirms the deduced code. Guesses leave on a valid/ready
// handshake; each accepted guess is answered by one fb_valid strobe.
module mastermind_solver
  import mastermind_pkg::*;
#(
  parameter int MAX_GUESSES = 20
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  output logic [GUESS_W-1:0] guess,
  output logic               guess_valid,
  input  logic               guess_ready,
  input  logic               fb_valid,
  input  logic [2:0]         red,
  input  logic [2:0]         white,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [GUESS_W-1:0] solved_code,
  output logic [4:0]         guess_count
);

  solver_state_t      state_q, state_n, wait_state;
  logic [COLOR_W-1:0] color_q, color_n;
  logic [1:0]         pos_q, pos_n;
  logic [COLOR_W-1:0] cand_q, cand_n;
  logic [GUESS_W-1:0] guess_q, guess_n, solved_q, solved_n, payload;
  logic               gv_q, gv_n;
  logic [4:0]         count_q, count_n, count_inc;
  logic               budget_hit;

  logic               tbl_clear, tbl_wr, tbl_dec;
  logic [2:0]         tbl_rd_count;
  logic [3:0]         tbl_sum, tbl_remaining, sum_next;
  logic [COLOR_W-1:0] tbl_filler;
  logic               tbl_filler_known, filler_ok;

  // The strategy uses only exact matches.
  logic unused_white;
  assign unused_white = ^white;

  // Candidate colour at one position, filler everywhere else.
  function automatic logic [GUESS_W-1:0] place_guess(input logic [1:0]         pos,
                                                     input logic [COLOR_W-1:0] col,
                                                     input logic [COLOR_W-1:0] fill);
    logic [GUESS_W-1:0] g;
    g = pack_guess(fill, fill, fill, fill);
    g[int'(pos)*COLOR_W +: COLOR_W] = col;
    return g;
  endfunction

  mastermind_color_table u_table (
    .clk          (clk),
    .resetn       (resetn),
    .clear        (tbl_clear),
    .wr_en        (tbl_wr),
    .wr_idx       (color_q),
    .wr_val       (red),
    .dec_en       (tbl_dec),
    .dec_idx      (cand_q),
    .rd_idx       (cand_q),
    .rd_count     (tbl_rd_count),
    .sum          (tbl_sum),
    .remaining    (tbl_remaining),
    .filler       (tbl_filler),
    .filler_known (tbl_filler_known)
  );

  assign count_inc  = (count_q == 5'd31) ? count_q : count_q + 5'd1;
  assign budget_hit = (int'(count_q) + 1) >= MAX_GUESSES;
  assign sum_next   = tbl_sum + {1'b0, red};
  assign filler_ok  = tbl_filler_known | (red == 3'd0);

  // Next-state and datapath update for the solver FSM.
  always_comb begin
    state_n    = state_q;
    color_n    = color_q;
    pos_n      = pos_q;
    cand_n     = cand_q;
    guess_n    = guess_q;
    gv_n       = gv_q;
    count_n    = count_q;
    solved_n   = solved_q;
    tbl_clear  = 1'b0;
    tbl_wr     = 1'b0;
    tbl_dec    = 1'b0;
    payload    = guess_q;
    wait_state = state_q;

    case (state_q)
      IDLE, DONE, FAIL: begin
        if (start) begin
          state_n   = SWEEP_ISSUE;
          color_n   = '0;
          pos_n     = '0;
          cand_n    = '0;
          count_n   = '0;
          solved_n  = '0;
          gv_n      = 1'b0;
          tbl_clear = 1'b1;
        end
      end

      SWEEP_ISSUE, PLACE_ISSUE, FINAL_ISSUE: begin
        if (state_q == SWEEP_ISSUE) begin
          payload    = pack_guess(color_q, color_q, color_q, color_q);
          wait_state = SWEEP_WAIT;
        end else if (state_q == PLACE_ISSUE) begin
          payload    = place_guess(pos_q, cand_q, tbl_filler);
          wait_state = PLACE_WAIT;
        end else begin
          payload    = solved_q;
          wait_state = FINAL_WAIT;
        end
        if (!gv_q) begin
          gv_n    = 1'b1;
          guess_n = payload;
        end else if (guess_ready) begin
          gv_n    = 1'b0;
          count_n = count_inc;
          // The confirming guess may still succeed, so it is never cut short.
          if (budget_hit && state_q != FINAL_ISSUE) state_n = FAIL;
          else                                      state_n = wait_state;
        end
      end

      SWEEP_WAIT: begin
        if (fb_valid) begin
          tbl_wr = 1'b1;
          if (sum_next == 4'd4 && filler_ok) begin
            state_n = PLACE_SEL;
            pos_n   = '0;
            cand_n  = '0;
          end else if (sum_next > 4'd4 || color_q == 3'd7) begin
            state_n = FAIL;
          end else begin
            color_n = color_q + 3'd1;
            state_n = SWEEP_ISSUE;
          end
        end
      end

      PLACE_SEL: begin
        if (tbl_rd_count == 3'd0) begin
          if (cand_q == 3'd7) state_n = FAIL;
          else                cand_n  = cand_q + 3'd1;
        end else if ({1'b0, tbl_rd_count} == tbl_remaining) begin
          // Only one colour remains: the position is forced, no guess needed.
          solved_n[int'(pos_q)*COLOR_W +: COLOR_W] = cand_q;
          tbl_dec = 1'b1;
          if (pos_q == 2'd3) begin
            state_n = FINAL_ISSUE;
          end else begin
            pos_n  = pos_q + 2'd1;
            cand_n = '0;
          end
        end else begin
          state_n = PLACE_ISSUE;
        end
      end

      PLACE_WAIT: begin
        if (fb_valid) begin
          if (red == 3'd1) begin
            solved_n[int'(pos_q)*COLOR_W +: COLOR_W] = cand_q;
            tbl_dec = 1'b1;
            if (pos_q == 2'd3) begin
              state_n = FINAL_ISSUE;
            end else begin
              pos_n   = pos_q + 2'd1;
              cand_n  = '0;
              state_n = PLACE_SEL;
            end
          end else if (red == 3'd0 && cand_q != 3'd7) begin
            cand_n  = cand_q + 3'd1;
            state_n = PLACE_SEL;
          end else begin
            state_n = FAIL;
          end
        end
      end

      FINAL_WAIT: begin
        if (fb_valid) state_n = (red == 3'd4) ? DONE : FAIL;
      end

      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any outstanding guess.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      color_q  <= '0;
      pos_q    <= '0;
      cand_q   <= '0;
      guess_q  <= '0;
      gv_q     <= 1'b0;
      count_q  <= '0;
      solved_q <= '0;
    end else begin
      state_q  <= state_n;
      color_q  <= color_n;
      pos_q    <= pos_n;
      cand_q   <= cand_n;
      guess_q  <= guess_n;
      gv_q     <= gv_n;
      count_q  <= count_n;
      solved_q <= solved_n;
    end
  end

  assign guess       = guess_q;
  assign guess_valid = gv_q;
  assign guess_count = count_q;
  assign solved_code = solved_q;
  assign done        = (state_q == DONE);
  assign fail        = (state_q == FAIL);
  assign busy        = (state_q != IDLE) && (state_q != DONE) && (state_q != FAIL);

endmodule

// File: tb/tb_mastermind_solver.sv
// Directed bench for mastermind_solver: a behavioural scorer answers each
// accepted guess; a table of games plus hand-written start/reset sequences.
module tb_mastermind_solver;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [11:0] guess;
  logic        guess_valid;
  logic        guess_ready;
  logic        fb_valid;
  logic [2:0]  red;
  logic [2:0]  white;
  logic        busy;
  logic        done;
  logic        fail;
  logic [11:0] solved_code;
  logic [4:0]  guess_count;

  int n_tests = 0;
  int n_fail  = 0;

  mastermind_solver dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .guess       (guess),
    .guess_valid (guess_valid),
    .guess_ready (guess_ready),
    .fb_valid    (fb_valid),
    .red         (red),
    .white       (white),
    .busy        (busy),
    .done        (done),
    .fail        (fail),
    .solved_code (solved_code),
    .guess_count (guess_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] secret;
    int          stall;    // cycles guess_ready stays low on each guess
    bit          zero;     // scorer always answers red=0
    bit          spur;     // spurious fb_valid during the first SWEEP_ISSUE
    bit          exp_done;
    bit          exp_fail;
    logic [11:0] exp_code;
    int          exp_count;
    int          n_sweep;  // leading guesses that must be c,c,c,c for c=0,1,..
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] score_red(input logic [11:0] g, input logic [11:0] s);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (g[i*3 +: 3] == s[i*3 +: 3]) r++;
    return 3'(r);
  endfunction

  task automatic wait_gv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (guess_valid) ok = 1'b1;
    end
  endtask

  task automatic run_game(input vec_t v, input int idx);
    int          wait_cnt;
    int          unstable;
    bit          fb_pend;
    bit          held_v;
    bit          spur_done;
    bit          finished;
    logic [2:0]  fb_red;
    logic [11:0] held;
    logic [11:0] gq[$];
    wait_cnt = 0; unstable = 0; fb_pend = 0; held_v = 0; spur_done = 0;
    finished = 0; fb_red = '0; held = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      @(negedge clk);
      fb_valid    = fb_pend;
      red         = fb_pend ? fb_red : 3'd0;
      white       = 3'd0;
      fb_pend     = 1'b0;
      guess_ready = 1'b0;
      if (done || fail) begin
        finished = 1'b1;
      end else begin
        if (held_v && (!guess_valid || guess !== held)) unstable++;
        if (guess_valid) begin
          if (!held_v) begin
            held     = guess;
            held_v   = 1'b1;
            wait_cnt = 0;
            if (v.spur && !spur_done) begin
              fb_valid  = 1'b1;
              red       = 3'd4;
              spur_done = 1'b1;
            end
          end
          if (wait_cnt >= v.stall) begin
            guess_ready = 1'b1;
            gq.push_back(held);
            fb_red  = v.zero ? 3'd0 : score_red(held, v.secret);
            fb_pend = 1'b1;
            held_v  = 1'b0;
          end else begin
            wait_cnt++;
          end
        end
      end
    end
    fb_valid = 1'b0;
    red      = 3'd0;
    check($sformatf("g%0d finished", idx), int'(finished), 1);
    repeat (3) @(negedge clk);
    check($sformatf("g%0d done", idx), int'(done), int'(v.exp_done));
    check($sformatf("g%0d fail", idx), int'(fail), int'(v.exp_fail));
    check($sformatf("g%0d solved_code", idx), int'(solved_code), int'(v.exp_code));
    check($sformatf("g%0d guess_count", idx), int'(guess_count), v.exp_count);
    check($sformatf("g%0d busy", idx), int'(busy), 0);
    check($sformatf("g%0d stable", idx), unstable, 0);
    for (int i = 0; i < v.n_sweep; i++) begin
      logic [2:0]  c;
      logic [11:0] eg;
      c  = 3'(i);
      eg = {c, c, c, c};
      check($sformatf("g%0d sweep%0d", idx, i), (i < gq.size()) ? int'(gq[i]) : -1, int'(eg));
    end
  endtask

  initial begin
    bit ok;
    vecs[0] = '{12'h688, 0, 0, 0, 1, 0, 12'h688,  9, 5};
    vecs[1] = '{12'hFFF, 0, 0, 0, 1, 0, 12'hFFF,  9, 8};
    vecs[2] = '{12'h000, 0, 1, 0, 0, 1, 12'h000,  8, 8};
    vecs[3] = '{12'hB45, 5, 0, 0, 1, 0, 12'hB45, 10, 6};
    vecs[4] = '{12'h688, 2, 0, 1, 1, 0, 12'h688,  9, 5};
    vecs[5] = '{12'h000, 0, 0, 0, 1, 0, 12'h000,  3, 2};
    vecs[6] = '{12'hC8A, 1, 0, 0, 1, 0, 12'hC8A, 12, 7};

    resetn = 1'b0; start = 1'b0; guess_ready = 1'b0;
    fb_valid = 1'b0; red = 3'd0; white = 3'd0;
    repeat (2) @(negedge clk);
    check("reset outputs", int'({guess, guess_valid, busy, done, fail, solved_code, guess_count}), 0);
    resetn = 1'b1;
    @(negedge clk);

    // Start latency, accept/feedback timing, then reset with a guess pending.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start busy", int'(busy), 1);
    check("start gv low", int'(guess_valid), 0);
    @(negedge clk);
    check("start gv high", int'(guess_valid), 1);
    check("first guess", int'(guess), 'h000);
    guess_ready = 1'b1;
    @(negedge clk);
    guess_ready = 1'b0;
    check("gv drops after accept", int'(guess_valid), 0);
    fb_valid = 1'b1; red = 3'd1;
    @(negedge clk);
    fb_valid = 1'b0; red = 3'd0;
    check("gv low after fb", int'(guess_valid), 0);
    wait_gv(ok);
    check("second guess offered", int'(ok), 1);
    check("second guess", int'(guess), 'h249);
    check("count after one", int'(guess_count), 1);
    #2 resetn = 1'b0;
    #1;
    check("async reset outputs", int'({guess, guess_valid, busy, done, fail, solved_code, guess_count}), 0);
    @(negedge clk);
    resetn = 1'b1;
    run_game(vecs[0], 99);

    for (int i = 0; i < 7; i++) run_game(vecs[i], i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
